// File: rtl/conv_pkg.sv
// Shared types and default geometry for the 3x3 convolution datapath.
// The line-buffer shift heap and the pooling controller also use this package.
package conv_pkg;

  localparam int IMG_W_DEF = 32;
  localparam int IMG_H_DEF = 32;
  localparam int KSIZE_DEF = 3;

  // Pixels that must already be in the heap before the next accept can complete a window.
  localparam int FILL_CNT = (KSIZE_DEF - 1) * IMG_W_DEF + KSIZE_DEF - 1;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    LAST,
    DONE
  } ctrl_state_t;

  function automatic int fill_count(input int img_w, input int ksize);
    return (ksize - 1) * img_w + ksize - 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order row/column position counter with increment enable.
// Provides end-of-line and end-of-frame flags for the current position.
module raster_counter #(
  parameter int W  = 32,
  parameter int H  = 32,
  parameter int CW = $clog2(W),
  parameter int RW = $clog2(H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          inc,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          col_last,
  output logic          row_last
);

  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

  assign col_last = (col == COL_MAX);
  assign row_last = (row == ROW_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/line_buf_ctrl.sv
// Sequencer for the 3-row line-buffer shift heap feeding the KSIZE x KSIZE window.
// Accepts a raster pixel stream and presents one-deep window-valid to the MAC array.
module line_buf_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int KSIZE = KSIZE_DEF,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          shift_en,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          busy,
  output logic          frame_done
);

  localparam logic [RW-1:0] EDGE_R = RW'(KSIZE - 1);
  localparam logic [CW-1:0] EDGE_C = CW'(KSIZE - 1);
  localparam logic [CW-1:0] FILL_C = CW'(KSIZE - 2);

  ctrl_state_t   state, state_next;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          col_last, row_last, frame_last;
  logic          accept, consume, win_hit, clear;

  // A held window blocks new pixels unless it is being consumed this cycle.
  assign consume    = win_valid && win_ready;
  assign in_ready   = ((state == FILL) || (state == RUN)) && !(win_valid && !win_ready);
  assign accept     = in_valid && in_ready;
  assign shift_en   = accept;
  assign win_hit    = accept && (row >= EDGE_R) && (col >= EDGE_C);
  assign clear      = (state == IDLE) && start;
  assign frame_last = col_last && row_last;

  assign busy       = (state == FILL) || (state == RUN) || (state == LAST);
  assign frame_done = (state == DONE);

  raster_counter #(
    .W (IMG_W),
    .H (IMG_H),
    .CW(CW),
    .RW(RW)
  ) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .inc     (accept),
    .row     (row),
    .col     (col),
    .col_last(col_last),
    .row_last(row_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = FILL;
      FILL: if (accept && (row == EDGE_R) && (col == FILL_C)) state_next = RUN;
      RUN:  if (accept && frame_last) state_next = LAST;
      LAST: if (!win_valid || win_ready) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Coordinates of the window's top-left pixel; the subtraction only happens on a hit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (win_hit) begin
      win_valid <= 1'b1;
      win_row   <= row - EDGE_R;
      win_col   <= col - EDGE_C;
    end else if (consume) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Randomized self-checking bench for line_buf_ctrl against a pixel-count based model.
// Frames: directed with backpressure, random, random with mid-frame reset, random with stray start.
module tb_line_buf_ctrl;

  localparam int W  = 32;
  localparam int H  = 32;
  localparam int K  = 3;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam int OW = W - K + 1;
  localparam int OH = H - K + 1;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, win_ready;
  logic          in_ready, shift_en, win_valid, busy, frame_done;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;

  line_buf_ctrl #(.IMG_W(W), .IMG_H(H), .KSIZE(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .shift_en  (shift_en),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_row   (win_row),
    .win_col   (win_col),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: phase 0 idle, 1 streaming pixels, 2 draining last window, 3 done pulse.
  int m_phase = 0;
  int m_accepts = 0;
  bit m_wv = 1'b0;
  int m_wr = 0;
  int m_wc = 0;

  int f_shifts, f_windows, f_done, f_first, exp_k;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    bit e_ready;
    e_ready = (m_phase == 1) && !(m_wv && !win_ready);
    check("in_ready", int'(in_ready), int'(e_ready));
    check("shift_en", int'(shift_en), int'(in_valid && e_ready));
    check("win_valid", int'(win_valid), int'(m_wv));
    if (m_wv) begin
      check("win_row", int'(win_row), m_wr);
      check("win_col", int'(win_col), m_wc);
    end
    check("busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
    check("frame_done", int'(frame_done), int'(m_phase == 3));
  endtask

  // Independent raster-order scoreboard driven by the DUT handshake.
  task automatic scoreboard();
    if (win_valid && f_first < 0) f_first = f_shifts;
    if (win_valid && win_ready) begin
      check("order_row", int'(win_row), exp_k / OW);
      check("order_col", int'(win_col), exp_k % OW);
      if (exp_k == 0)   check("first_win", int'(win_row) * 100 + int'(win_col), 0);
      if (exp_k == 90)  check("wrap_start", int'(win_row) * 100 + int'(win_col), 300);
      if (exp_k == 119) check("wrap_end", int'(win_row) * 100 + int'(win_col), 329);
      exp_k++;
      f_windows++;
    end
    if (shift_en) f_shifts++;
    if (frame_done) begin
      f_done++;
      check("busy_at_done", int'(busy), 0);
    end
  endtask

  task automatic modelStep();
    bit e_ready, acc, cons;
    int r, c;
    e_ready = (m_phase == 1) && !(m_wv && !win_ready);
    acc  = in_valid && e_ready;
    cons = m_wv && win_ready;
    if (!rst_n) begin
      m_phase = 0; m_wv = 1'b0; m_accepts = 0;
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_accepts = 0; end
        1: begin
          if (acc) begin
            r = m_accepts / W;
            c = m_accepts % W;
            m_accepts++;
            if (r >= K - 1 && c >= K - 1) begin
              m_wv = 1'b1; m_wr = r - (K - 1); m_wc = c - (K - 1);
            end else if (cons) m_wv = 1'b0;
          end else if (cons) m_wv = 1'b0;
          if (m_accepts == W * H) m_phase = 2;
        end
        2: if (!m_wv || win_ready) begin m_phase = 3; m_wv = 1'b0; end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic applyStimulus(input bit rs, input bit st, input bit v, input bit rd);
    @(negedge clk);
    rst_n = rs; start = st; in_valid = v; win_ready = rd;
    #1;
    checkOutput();
    scoreboard();
    modelStep();
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_win_valid"}, int'(win_valid), 0);
    check({tag, "_win_row"}, int'(win_row), 0);
    check({tag, "_win_col"}, int'(win_col), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  // mode 0 directed + backpressure, 1 random, 2 random + reset at pixel 300, 3 random + start at pixel 100
  task automatic runFrame(input int mode);
    int cyc, bp;
    bit done, v, rd, st, rs, st_sent;
    cyc = 0; bp = 0; done = 1'b0; st_sent = 1'b0;
    f_shifts = 0; f_windows = 0; f_done = 0; f_first = -1; exp_k = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    while (!done && cyc < 20000) begin
      rs = 1'b1; st = 1'b0;
      if (mode == 0) begin
        v = 1'b1; rd = 1'b1;
        if (m_wv && m_wr == 4 && m_wc == 7 && bp < 10) begin rd = 1'b0; bp++; end
      end else begin
        v  = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 3) != 0);
      end
      if (mode == 3 && m_phase == 1 && m_accepts == 100 && !st_sent) begin
        st = 1'b1; st_sent = 1'b1;
      end
      if (mode == 2 && m_phase == 1 && m_accepts == 300) rs = 1'b0;
      applyStimulus(rs, st, v, rd);
      if (mode == 0 && !rd) begin
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_shift_en", int'(shift_en), 0);
        check("bp_win_valid", int'(win_valid), 1);
        check("bp_win_row", int'(win_row), 4);
        check("bp_win_col", int'(win_col), 7);
      end
      if (!rs) begin
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkResetValues("midreset");
        check("midreset_shift_en", int'(shift_en), 0);
        done = 1'b1;
      end
      if (f_done > 0) done = 1'b1;
      cyc++;
    end
    if (!done) check("frame_timeout", 0, 1);
    check("first_win_accepts", f_first, 67);
    if (mode == 0) check("bp_cycles", bp, 10);
    if (mode == 3) check("stray_start_sent", int'(st_sent), 1);
    if (mode != 2) begin
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      check("window_count", f_windows, OW * OH);
      check("shift_count", f_shifts, W * H);
      check("done_pulses", f_done, 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; win_ready = 1'b0;
    repeat (2) @(posedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkResetValues("reset");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    runFrame(0);
    runFrame(1);
    runFrame(2);
    runFrame(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/line_buf_ctrl.md
Name: line_buf_ctrl

Overview:
- Sequencer for the 3-row line-buffer shift heap that feeds the 3x3 convolution window.
- Accepts a raster pixel stream over a valid/ready handshake and drives the heap's shift enable.
- Tracks row/column position and flags when the heap holds a complete KSIZE x KSIZE window.
- Presents window-valid to the MAC array with backpressure and pulses frame_done at end of frame.

Parameters:
IMG_W, 32, pixels per line (equals heap row length)
IMG_H, 32, lines per frame
KSIZE, 3, window edge; the first valid window needs KSIZE-1 full lines plus KSIZE pixels
CW, $clog2(IMG_W), column counter width (derived)
RW, $clog2(IMG_H), row counter width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse; begins a frame when idle
in_valid  in  1  upstream pixel valid
in_ready  out  1  controller can accept a pixel
shift_en  out  1  heap shift enable (= in_valid & in_ready, combinational)
win_valid  out  1  heap currently holds a complete window (registered)
win_ready  in  1  consumer accepts the window
win_row  out  RW  output row of the window's top-left pixel
win_col  out  CW  output column of the window's top-left pixel
busy  out  1  high from start accept until frame_done
frame_done  out  1  one-cycle pulse when the last window is consumed

Behaviour:
- Reset values: in_ready=0, win_valid=0, win_row=0, win_col=0, busy=0, frame_done=0. State=IDLE, counters=0. shift_en=0 follows from in_ready=0.
- FSM states: IDLE, FILL, RUN, LAST, DONE.
- IDLE to FILL on start. busy=1 from the next cycle. Counters are cleared on entry.
- FILL: pixels are accepted but cannot complete a window. Move to RUN when the accepted pixel has row=KSIZE-1 and col=KSIZE-2, i.e. the next pixel can complete a window.
- RUN to LAST when pixel (IMG_H-1, IMG_W-1) is accepted. LAST waits for the final window to be consumed, then goes to DONE.
- DONE: frame_done=1 for exactly one cycle, busy drops in the same cycle, then return to IDLE.
- Accept: a pixel is accepted when in_valid & in_ready. On acceptance, col increments; when it wraps from IMG_W-1 to 0, row increments.
- in_ready = state in {FILL, RUN} and not (win_valid and not win_ready). This allows a one-deep window with pass-through on consume.
- shift_en is high exactly on accept cycles. The heap captures the pixel on that same edge.
- Window condition: the accepted pixel at (r, c) satisfies r>=KSIZE-1 and c>=KSIZE-1.
  - On the next cycle, win_valid=1, win_row=r-(KSIZE-1), win_col=c-(KSIZE-1).
  - win_valid is held, with stable coordinates, until win_valid & win_ready.
- Latency: pixel accept to win_valid is 1 cycle.
- Consume and new window in the same cycle: win_valid stays 1 and the coordinates update.
- Line-start pixels (c < KSIZE-1) produce no window; win_valid clears on consume.
- Window count per frame: (IMG_H-KSIZE+1)*(IMG_W-KSIZE+1).
- start while busy: ignored.
- in_valid outside FILL/RUN: ignored, no shift.
- Reset mid-frame: everything returns to reset values on the next edge, and any pending window is dropped. Heap contents are stale and are overwritten by the next fill.
- Counter arithmetic is unsigned. Coordinate subtraction occurs only when the window condition holds, so it never underflows.

Decomposition:
- Shared package conv_pkg:
  - FSM state enum (IDLE, FILL, RUN, LAST, DONE).
  - Default IMG_W/IMG_H/KSIZE localparams, also used by the shift heap.
  - FILL_CNT = (KSIZE-1)*IMG_W + KSIZE - 1.
- One natural sub-module, raster_counter: row/col counter with an increment enable and wrap/last flags. It is reused later by the pooling controller.

Test Plan:
- Fill latency (defaults, in_valid held 1, win_ready=1): start, then stream pixels. The first win_valid appears the cycle after the 67th accept (row 2, col 2), with win_row=0, win_col=0; no win_valid before that.
- Line wrap: within row 5, the accepts at col 0 and col 1 produce no window. The accept at col 2 gives win_row=3, win_col=0. The accept at col 31 gives win_row=3, win_col=29.
- Backpressure: win_ready=0 for 10 cycles at window (4,7). win_valid and the coordinates stay stable, in_ready=0, and no shift_en pulses occur. Release win_ready and the stream resumes with no lost or duplicated windows.
- Full frame with random in_valid and win_ready: exactly 900 windows are seen, each (row, col) in 0..29 appears once in raster order, and there are exactly 1024 shift_en pulses. frame_done pulses once after the last window is consumed, and busy falls in the same cycle.
- Mid-frame reset: assert rst_n=0 at pixel 300. The next cycle shows all outputs at reset values. A new start then produces a first window after 67 accepts again.
- Start while busy: pulse start at pixel 100. The counters are unaffected and the frame still yields 900 windows.
